// File: rtl/pipe_probe_bank.sv
// Bank of independent shift-register channels with a capture FSM that counts
// DEPTH valid shifts after an arm strobe and snapshots the resulting tail value.
module pipe_probe_bank #(
  parameter int               CHANNELS = 4,
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] PRESET   = '0
) (
  input  logic [63:0] clkin_data,
  input  logic [31:0] in_data,
  output logic [31:0] out_data,
  output logic [31:0] probe_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic             clk;
  logic             srst;
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic [1:0]       mode;
  logic             arm;

  assign clk  = clkin_data[0];
  assign srst = clkin_data[32];
  assign din  = in_data[WIDTH-1:0];
  assign sel  = in_data[9:8];
  assign mode = in_data[11:10];
  assign arm  = in_data[12];

  logic unused_bits;
  assign unused_bits = ^{clkin_data[63:33], clkin_data[31:1], in_data[31:13], in_data[7:0]};

  logic [CHANNELS-1:0]       ch_hit;
  logic [CHANNELS*WIDTH-1:0] tail_q_all;
  logic [CHANNELS*WIDTH-1:0] tail_d_all;

  // One shift register per channel; only the channel matching sel reacts.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] st_q [DEPTH];
    logic [WIDTH-1:0] st_d [DEPTH];

    assign ch_hit[gi] = (sel == 2'(gi));

    always_comb begin
      for (int k = 0; k < DEPTH; k++) st_d[k] = st_q[k];
      if (ch_hit[gi]) begin
        case (mode)
          2'b01: begin
            st_d[0] = din;
            for (int k = 1; k < DEPTH; k++) st_d[k] = st_q[k-1];
          end
          2'b10:   for (int k = 0; k < DEPTH; k++) st_d[k] = PRESET;
          2'b11:   for (int k = 0; k < DEPTH; k++) st_d[k] = '0;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (srst) st_q[k] <= '0;
        else      st_q[k] <= st_d[k];
      end
    end

    assign tail_q_all[gi*WIDTH +: WIDTH] = st_q[DEPTH-1];
    assign tail_d_all[gi*WIDTH +: WIDTH] = st_d[DEPTH-1];
  end

  logic sel_valid;
  logic valid_shift;
  logic valid_lc;

  assign sel_valid   = |ch_hit;
  assign valid_shift = sel_valid && (mode == 2'b01);
  assign valid_lc    = sel_valid && mode[1];

  // Post-shift tail of the selected channel, taken from next-state values.
  logic [WIDTH-1:0] snap_src;
  always_comb begin
    snap_src = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_hit[c]) snap_src = tail_d_all[c*WIDTH +: WIDTH];
    end
  end

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cnt_inc;
  logic [7:0]       cap_q, cap_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             done_hit;

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    snap_d   = snap_q;
    done_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (valid_shift) begin
          cnt_d = 4'd1;
          if (DEPTH == 1) begin
            state_d  = DONE;
            done_hit = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end
      COUNT: begin
        // Hold cycles and arm strobes fall through untouched here.
        if (valid_shift) begin
          cnt_d = cnt_inc;
          if (cnt_inc == 4'(DEPTH)) begin
            state_d  = DONE;
            done_hit = 1'b1;
          end
        end else if (valid_lc) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      DONE: begin
        if (arm) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_hit) begin
      snap_d = snap_src;
      if (cap_q != 8'hFF) cap_d = cap_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cap_q   <= 8'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    out_data = '0;
    out_data[CHANNELS*WIDTH-1:0] = tail_q_all;
  end

  assign probe_data = {8'h00, 8'(snap_q), cap_q, 6'b0, state_q};

endmodule

// File: tb/tb_pipe_probe_bank.sv
// Bench for pipe_probe_bank: directed vector table, DEPTH==1 / no-op corners,
// capture-count saturation and random traffic against a behavioural model.
module tb_pipe_probe_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  wire  [63:0] clkin_data = {31'b0, rst, 31'b0, clk};

  logic [31:0] out1, probe1, out2, probe2;

  always #5 clk = ~clk;

  pipe_probe_bank #(.CHANNELS(4), .WIDTH(8), .DEPTH(4), .PRESET(8'h5A)) dut1 (
    .clkin_data(clkin_data), .in_data(in_data), .out_data(out1), .probe_data(probe1)
  );

  pipe_probe_bank #(.CHANNELS(2), .WIDTH(5), .DEPTH(1), .PRESET(5'h15)) dut2 (
    .clkin_data(clkin_data), .in_data(in_data), .out_data(out2), .probe_data(probe2)
  );

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Reference model: instance 0 mirrors dut1, instance 1 mirrors dut2.
  int m_stage [2][4][8];
  int m_state [2];
  int m_cnt   [2];
  int m_cap   [2];
  int m_snap  [2];

  function automatic int pch(int i);  return (i == 0) ? 4 : 2;        endfunction
  function automatic int pw(int i);   return (i == 0) ? 8 : 5;        endfunction
  function automatic int pd(int i);   return (i == 0) ? 4 : 1;        endfunction
  function automatic int ppre(int i); return (i == 0) ? 'h5A : 'h15;  endfunction

  function automatic logic [31:0] mk(bit a, logic [1:0] mode, logic [1:0] sel, logic [7:0] d);
    return {19'b0, a, mode, sel, d};
  endfunction

  task automatic model_step(int i, logic r, logic [31:0] d);
    int  ch, dp, sel, mode, dv;
    bit  ok, vs, vlc, done;
    ch   = pch(i);
    dp   = pd(i);
    sel  = int'(d[9:8]);
    mode = int'(d[11:10]);
    dv   = int'(d[7:0]) & ((1 << pw(i)) - 1);
    if (r) begin
      for (int c = 0; c < 4; c++) for (int k = 0; k < 8; k++) m_stage[i][c][k] = 0;
      m_state[i] = 0; m_cnt[i] = 0; m_cap[i] = 0; m_snap[i] = 0;
      return;
    end
    ok   = sel < ch;
    vs   = ok && mode == 1;
    vlc  = ok && mode >= 2;
    done = 0;
    if (ok) begin
      if (mode == 1) begin
        for (int k = dp - 1; k > 0; k--) m_stage[i][sel][k] = m_stage[i][sel][k-1];
        m_stage[i][sel][0] = dv;
      end else if (mode == 2) begin
        for (int k = 0; k < dp; k++) m_stage[i][sel][k] = ppre(i);
      end else if (mode == 3) begin
        for (int k = 0; k < dp; k++) m_stage[i][sel][k] = 0;
      end
    end
    if (m_state[i] == 0) begin
      if (d[12]) m_state[i] = 1;
    end else if (m_state[i] == 1) begin
      if (vs) begin
        m_cnt[i] = 1;
        if (m_cnt[i] == dp) begin m_state[i] = 3; done = 1; end
        else m_state[i] = 2;
      end
    end else if (m_state[i] == 2) begin
      if (vs) begin
        m_cnt[i]++;
        if (m_cnt[i] == dp) begin m_state[i] = 3; done = 1; end
      end else if (vlc) begin
        m_state[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      if (d[12]) begin m_state[i] = 0; m_cnt[i] = 0; end
    end
    if (done) begin
      m_snap[i] = m_stage[i][sel][dp-1];
      if (m_cap[i] < 255) m_cap[i]++;
    end
  endtask

  function automatic logic [31:0] model_out(int i);
    int v = 0;
    for (int c = 0; c < pch(i); c++) v |= m_stage[i][c][pd(i)-1] << (c * pw(i));
    return 32'(v);
  endfunction

  function automatic logic [31:0] model_probe(int i);
    return 32'((m_snap[i] << 16) | (m_cap[i] << 8) | m_state[i]);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d got=%08h want=%08h", name, txn, act, exp);
    end
  endtask

  // Drive one cycle, advance the model on the edge, compare on the falling edge.
  task automatic cycle(logic r, logic [31:0] d);
    rst = r;
    in_data = d;
    @(posedge clk);
    model_step(0, r, d);
    model_step(1, r, d);
    @(negedge clk);
    txn++;
    $display("txn %0d rst=%b in=%08h out1=%08h probe1=%08h out2=%08h probe2=%08h",
             txn, r, d, out1, probe1, out2, probe2);
    check("model_out1", out1, model_out(0));
    check("model_probe1", probe1, model_probe(0));
    check("model_out2", out2, model_out(1));
    check("model_probe2", probe2, model_probe(1));
  endtask

  typedef struct {
    logic        r;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic [31:0] exp_probe;
  } vec_t;

  vec_t vt [22];

  initial begin
    vt[0]  = '{1'b1, mk(0, 2'b01, 0, 8'hFF), 32'h0,          32'h0};
    vt[1]  = '{1'b0, mk(0, 2'b01, 0, 8'h11), 32'h0,          32'h0};
    vt[2]  = '{1'b0, mk(0, 2'b01, 0, 8'h22), 32'h0,          32'h0};
    vt[3]  = '{1'b0, mk(0, 2'b01, 0, 8'h33), 32'h0,          32'h0};
    vt[4]  = '{1'b0, mk(0, 2'b01, 0, 8'h44), 32'h00000011,   32'h0};
    vt[5]  = '{1'b0, mk(0, 2'b01, 0, 8'h55), 32'h00000022,   32'h0};
    vt[6]  = '{1'b0, mk(1, 2'b00, 0, 8'h00), 32'h00000022,   32'h00000001};
    vt[7]  = '{1'b0, mk(0, 2'b01, 1, 8'hA1), 32'h00000022,   32'h00000002};
    vt[8]  = '{1'b0, mk(0, 2'b01, 1, 8'hA2), 32'h00000022,   32'h00000002};
    vt[9]  = '{1'b0, mk(0, 2'b01, 1, 8'hA3), 32'h00000022,   32'h00000002};
    vt[10] = '{1'b0, mk(0, 2'b01, 1, 8'hA4), 32'h0000A122,   32'h00A10103};
    vt[11] = '{1'b0, mk(1, 2'b00, 0, 8'h00), 32'h0000A122,   32'h00A10100};
    vt[12] = '{1'b0, mk(1, 2'b00, 0, 8'h00), 32'h0000A122,   32'h00A10101};
    vt[13] = '{1'b0, mk(0, 2'b01, 2, 8'h01), 32'h0000A122,   32'h00A10102};
    vt[14] = '{1'b0, mk(0, 2'b01, 3, 8'h02), 32'h0000A122,   32'h00A10102};
    vt[15] = '{1'b0, mk(0, 2'b10, 2, 8'h00), 32'h005AA122,   32'h00A10100};
    vt[16] = '{1'b0, mk(1, 2'b00, 0, 8'h00), 32'h005AA122,   32'h00A10101};
    vt[17] = '{1'b0, mk(0, 2'b01, 3, 8'h10), 32'h005AA122,   32'h00A10102};
    vt[18] = '{1'b0, mk(1, 2'b00, 3, 8'h00), 32'h005AA122,   32'h00A10102};
    vt[19] = '{1'b0, mk(0, 2'b01, 3, 8'h20), 32'h005AA122,   32'h00A10102};
    vt[20] = '{1'b1, mk(0, 2'b01, 3, 8'h30), 32'h0,          32'h0};
    vt[21] = '{1'b0, mk(0, 2'b11, 0, 8'h00), 32'h0,          32'h0};

    @(negedge clk);

    for (int i = 0; i < 22; i++) begin
      cycle(vt[i].r, vt[i].din);
      check("vec_out", out1, vt[i].exp_out);
      check("vec_probe", probe1, vt[i].exp_probe);
    end

    // Second instance: out-of-range selects are no-ops; DEPTH==1 captures on first shift.
    cycle(1'b1, 32'h0);
    cycle(1'b0, mk(1, 2'b00, 0, 8'h00));
    cycle(1'b0, mk(0, 2'b01, 3, 8'h1F));
    cycle(1'b0, mk(0, 2'b10, 3, 8'h00));
    cycle(1'b0, mk(0, 2'b11, 2, 8'h00));
    check("sel3_noop_out", out2, 32'h0);
    check("sel3_noop_probe", probe2, 32'h00000001);
    cycle(1'b0, mk(0, 2'b01, 1, 8'h13));
    check("depth1_out", out2, 32'h00000260);
    check("depth1_probe", probe2, 32'h00130103);

    // Capture-count saturation.
    cycle(1'b1, 32'h0);
    for (int n = 0; n < 260; n++) begin
      cycle(1'b0, mk(1, 2'b00, 0, 8'h00));
      for (int s = 0; s < 4; s++) cycle(1'b0, mk(0, 2'b01, 0, 8'($urandom)));
      cycle(1'b0, mk(1, 2'b00, 0, 8'h00));
    end
    check("sat_cap1", {24'h0, probe1[15:8]}, 32'h000000FF);
    check("sat_cap2", {24'h0, probe2[15:8]}, 32'h000000FF);

    // Random traffic, biased toward shifts so captures complete regularly.
    for (int n = 0; n < 800; n++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom);
      cycle($urandom_range(0, 63) == 0,
            mk($urandom_range(0, 7) == 0, m, 2'($urandom), 8'($urandom)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
